// File: rtl/spi_reg_loader_pkg.sv
// Shared constants for spi_reg_loader: frame FSM encoding, B1 field layout and width limits.
package spi_reg_loader_pkg;

  localparam int MAX_ADDR_W = 12;
  localparam int MAX_DATA_W = 16;
  localparam int MAX_BANKS  = 8;

  localparam int B1_TGT_BIT  = 7;
  localparam int B1_BANK_MSB = 6;
  localparam int B1_BANK_LSB = 4;
  localparam int B1_ADDR_W   = MAX_ADDR_W - 8;

  typedef enum logic [3:0] {
    ST_WAIT_B0 = 4'b0001,
    ST_WAIT_B1 = 4'b0010,
    ST_WAIT_B2 = 4'b0100,
    ST_WAIT_B3 = 4'b1000
  } state_t;

  function automatic int flag_idx_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  function automatic logic [MAX_DATA_W-1:0] join_bytes(input logic [7:0] hi, input logic [7:0] lo);
    return {hi, lo};
  endfunction

endpackage

// File: rtl/spi_reg_loader_if.sv
// Bus bundle between the SPI receiver / synth engine (master) and spi_reg_loader (slave).
interface spi_reg_loader_if #(
  parameter int ADDR_W = 10,
  parameter int DATA_W = 9,
  parameter int BANKS  = 2,
  parameter int FLAG_N = 16,
  parameter int FLAG_W = 2,
  parameter int ERR_W  = 8
);
  import spi_reg_loader_pkg::*;
  localparam int FA_W = flag_idx_w(FLAG_N);

  logic                    IO_SPI_data_ready;
  logic [7:0]              IO_SPI_data;
  logic                    IO_SPI_cs;
  logic [ADDR_W-1:0]       IO_R_Mem_addr;
  logic [BANKS*DATA_W-1:0] IO_R_Mem_value;
  logic                    IO_Flag_read;
  logic [FA_W-1:0]         IO_Flag_addr;
  logic [FLAG_W-1:0]       IO_Flag_value;
  logic                    IO_Frame_done;
  logic [ERR_W-1:0]        IO_Frame_err_cnt;

  modport master (
    output IO_SPI_data_ready, IO_SPI_data, IO_SPI_cs, IO_R_Mem_addr, IO_Flag_read, IO_Flag_addr,
    input  IO_R_Mem_value, IO_Flag_value, IO_Frame_done, IO_Frame_err_cnt
  );

  modport slave (
    input  IO_SPI_data_ready, IO_SPI_data, IO_SPI_cs, IO_R_Mem_addr, IO_Flag_read, IO_Flag_addr,
    output IO_R_Mem_value, IO_Flag_value, IO_Frame_done, IO_Frame_err_cnt
  );

endinterface

// File: rtl/spi_flag_file.sv
// Clear-on-read flag registers with write-wins collision handling.
// SPI_REG_LOADER_FLAG_OR_EN makes writes accumulate (OR) instead of overwrite.
module spi_flag_file
  import spi_reg_loader_pkg::*;
#(
  parameter int FLAG_N = 16,
  parameter int FLAG_W = 2,
  localparam int FA_W  = flag_idx_w(FLAG_N)
) (
  input  logic              i_clk,
  input  logic              i_rst_n,
  input  logic              i_wr_en,
  input  logic [FA_W-1:0]   i_wr_idx,
  input  logic [FLAG_W-1:0] i_wr_data,
  input  logic              i_rd_en,
  input  logic [FA_W-1:0]   i_rd_idx,
  output logic [FLAG_W-1:0] o_value
);

  logic [FLAG_W-1:0] r_flag [FLAG_N];
  logic [FLAG_W-1:0] w_wr_val;

  always_comb begin
    w_wr_val = i_wr_data;
`ifdef SPI_REG_LOADER_FLAG_OR_EN
    // A read of the same index clears the old bits, so only the new data survives.
    if (!(i_rd_en && (i_rd_idx == i_wr_idx)))
      w_wr_val = r_flag[i_wr_idx] | i_wr_data;
`endif
  end

  // The write is scheduled after the clear so it wins on a shared index.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      for (int i = 0; i < FLAG_N; i++) r_flag[i] <= '0;
      o_value <= '0;
    end else begin
      if (i_rd_en) begin
        o_value          <= r_flag[i_rd_idx];
        r_flag[i_rd_idx] <= '0;
      end
      if (i_wr_en) r_flag[i_wr_idx] <= w_wr_val;
    end
  end

endmodule

// File: rtl/spi_reg_loader.sv
// Decodes 4-byte SPI write frames into banked RAM writes or flag writes.
// Optional: SPI_REG_LOADER_FLAG_OR_EN (flag writes accumulate, see spi_flag_file).
module spi_reg_loader
  import spi_reg_loader_pkg::*;
#(
  parameter int ADDR_W = 10,
  parameter int DATA_W = 9,
  parameter int BANKS  = 2,
  parameter int FLAG_N = 16,
  parameter int FLAG_W = 2,
  parameter int ERR_W  = 8
) (
  input logic              IO_main_clk,
  input logic              IO_rst_n,
  spi_reg_loader_if.slave  bus
);

  localparam int FA_W = flag_idx_w(FLAG_N);
  localparam int BK_W = $clog2(MAX_BANKS);

  logic              r_cs_s1, r_cs_s2;
  state_t            r_state, w_state_nxt;
  logic              r_commit;
  logic [ERR_W-1:0]  r_err_cnt;
  logic              r_tgt;
  logic [BK_W-1:0]   r_bank;
  logic [ADDR_W-1:0] r_addr;
  logic [DATA_W-1:0] r_data;
  logic              w_accept, w_abort, w_bank_ok, w_bad_frame;
  logic [BANKS-1:0]  w_en;
  wire  [BANKS*DATA_W-1:0] w_rd_all;

  assign w_accept    = bus.IO_SPI_data_ready && !r_cs_s2;
  assign w_abort     = r_cs_s2 && (r_state != ST_WAIT_B0);
  assign w_bank_ok   = ({1'b0, r_bank} < (BK_W+1)'(BANKS));
  assign w_bad_frame = r_commit && !r_tgt && !w_bank_ok;

  always_ff @(posedge IO_main_clk or negedge IO_rst_n) begin
    if (!IO_rst_n) begin
      r_cs_s1   <= 1'b1;
      r_cs_s2   <= 1'b1;
      r_state   <= ST_WAIT_B0;
      r_commit  <= 1'b0;
      r_err_cnt <= '0;
    end else begin
      r_cs_s1  <= bus.IO_SPI_cs;
      r_cs_s2  <= r_cs_s1;
      r_state  <= w_state_nxt;
      r_commit <= w_accept && (r_state == ST_WAIT_B3);
      if ((w_abort || w_bad_frame) && (r_err_cnt != '1))
        r_err_cnt <= r_err_cnt + ERR_W'(1);
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    if (r_cs_s2) begin
      w_state_nxt = ST_WAIT_B0;
    end else if (bus.IO_SPI_data_ready) begin
      case (r_state)
        ST_WAIT_B0: w_state_nxt = ST_WAIT_B1;
        ST_WAIT_B1: w_state_nxt = ST_WAIT_B2;
        ST_WAIT_B2: w_state_nxt = ST_WAIT_B3;
        ST_WAIT_B3: w_state_nxt = ST_WAIT_B0;
        default:    w_state_nxt = ST_WAIT_B0;
      endcase
    end
  end

  // Frame fields hold until the next frame overwrites them, keeping addr/data stable at commit.
  always_ff @(posedge IO_main_clk) begin
    if (w_accept) begin
      case (r_state)
        ST_WAIT_B0: r_addr[7:0] <= bus.IO_SPI_data;
        ST_WAIT_B1: begin
          r_tgt  <= bus.IO_SPI_data[B1_TGT_BIT];
          r_bank <= bus.IO_SPI_data[B1_BANK_MSB:B1_BANK_LSB];
          r_addr <= ADDR_W'(join_bytes({{(8-B1_ADDR_W){1'b0}}, bus.IO_SPI_data[B1_ADDR_W-1:0]},
                                       r_addr[7:0]));
        end
        ST_WAIT_B2: r_data[7:0] <= bus.IO_SPI_data;
        ST_WAIT_B3: r_data <= DATA_W'(join_bytes(bus.IO_SPI_data, r_data[7:0]));
        default: ;
      endcase
    end
  end

  always_comb begin
    w_en = '0;
    for (int b = 0; b < BANKS; b++)
      w_en[b] = r_commit && !r_tgt && (int'(r_bank) == b);
  end

  for (genvar b = 0; b < BANKS; b++) begin : g_bank
    logic [DATA_W-1:0] r_mem [2**ADDR_W];
    logic [DATA_W-1:0] r_rd;

    always_ff @(posedge IO_main_clk) begin
      if (w_en[b]) r_mem[r_addr] <= r_data;
      r_rd <= r_mem[bus.IO_R_Mem_addr];
    end

    assign w_rd_all[b*DATA_W +: DATA_W] = r_rd;
  end

  assign bus.IO_R_Mem_value   = w_rd_all;
  assign bus.IO_Frame_done    = r_commit && (r_tgt || w_bank_ok);
  assign bus.IO_Frame_err_cnt = r_err_cnt;

  spi_flag_file #(
    .FLAG_N (FLAG_N),
    .FLAG_W (FLAG_W)
  ) u_flags (
    .i_clk     (IO_main_clk),
    .i_rst_n   (IO_rst_n),
    .i_wr_en   (r_commit && r_tgt),
    .i_wr_idx  (r_addr[FA_W-1:0]),
    .i_wr_data (r_data[FLAG_W-1:0]),
    .i_rd_en   (bus.IO_Flag_read),
    .i_rd_idx  (bus.IO_Flag_addr),
    .o_value   (bus.IO_Flag_value)
  );

endmodule

// File: tb/tb_spi_reg_loader.sv
// Directed bench for spi_reg_loader: RAM writes, flag file, aborts, bad banks, reset.
module tb_spi_reg_loader;

  localparam int ADDR_W = 10;
  localparam int DATA_W = 9;
  localparam int BANKS  = 2;
  localparam int FLAG_N = 16;
  localparam int FLAG_W = 2;
  localparam int ERR_W  = 8;

`ifdef SPI_REG_LOADER_FLAG_OR_EN
  localparam logic [1:0] EXP_ACC = 2'd3;
`else
  localparam logic [1:0] EXP_ACC = 2'd2;
`endif

  logic clk = 1'b0;
  logic rst_n;
  int   n_vec = 0;
  int   n_err = 0;
  int   done_cnt = 0;

  spi_reg_loader_if #(
    .ADDR_W(ADDR_W), .DATA_W(DATA_W), .BANKS(BANKS),
    .FLAG_N(FLAG_N), .FLAG_W(FLAG_W), .ERR_W(ERR_W)
  ) bus ();

  spi_reg_loader #(
    .ADDR_W(ADDR_W), .DATA_W(DATA_W), .BANKS(BANKS),
    .FLAG_N(FLAG_N), .FLAG_W(FLAG_W), .ERR_W(ERR_W)
  ) dut (
    .IO_main_clk (clk),
    .IO_rst_n    (rst_n),
    .bus         (bus)
  );

  always #5 clk = ~clk;

  always @(negedge clk) if (bus.IO_Frame_done === 1'b1) done_cnt++;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  task automatic send_byte(input logic [7:0] b);
    @(negedge clk);
    bus.IO_SPI_data_ready = 1'b1;
    bus.IO_SPI_data       = b;
    @(negedge clk);
    bus.IO_SPI_data_ready = 1'b0;
  endtask

  // Returns at the negedge inside the commit cycle.
  task automatic send_frame(input logic [7:0] b0, b1, b2, b3);
    send_byte(b0);
    send_byte(b1);
    send_byte(b2);
    send_byte(b3);
  endtask

  task automatic flag_read(input logic [3:0] idx);
    bus.IO_Flag_read = 1'b1;
    bus.IO_Flag_addr = idx;
    @(negedge clk);
    bus.IO_Flag_read = 1'b0;
  endtask

  task automatic mem_read(input logic [ADDR_W-1:0] a);
    bus.IO_R_Mem_addr = a;
    @(negedge clk);
  endtask

  task automatic test_reset;
    rst_n = 1'b0;
    bus.IO_SPI_cs = 1'b1;
    bus.IO_SPI_data_ready = 1'b0;
    bus.IO_SPI_data = 8'h00;
    bus.IO_R_Mem_addr = '0;
    bus.IO_Flag_read = 1'b0;
    bus.IO_Flag_addr = '0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    n_vec++; if (bus.IO_Frame_err_cnt !== 8'd0) begin n_err++; $display("FAIL reset_err: got %0d want 0", bus.IO_Frame_err_cnt); end
    n_vec++; if (bus.IO_Flag_value !== 2'd0) begin n_err++; $display("FAIL reset_flag_value: got %0d want 0", bus.IO_Flag_value); end
    n_vec++; if (bus.IO_Frame_done !== 1'b0) begin n_err++; $display("FAIL reset_done: got %b want 0", bus.IO_Frame_done); end
    bus.IO_SPI_cs = 1'b0;
    repeat (3) @(negedge clk);
  endtask

  task automatic test_mem_write;
    int d0;
    d0 = done_cnt;
    send_frame(8'h05, 8'h01, 8'hAB, 8'h01);
    n_vec++; if (bus.IO_Frame_done !== 1'b1) begin n_err++; $display("FAIL mem_done_pulse: got %b want 1", bus.IO_Frame_done); end
    @(negedge clk);
    n_vec++; if (bus.IO_Frame_done !== 1'b0) begin n_err++; $display("FAIL mem_done_width: got %b want 0", bus.IO_Frame_done); end
    n_vec++; if (done_cnt !== d0 + 1) begin n_err++; $display("FAIL mem_done_count: got %0d want %0d", done_cnt, d0 + 1); end
    mem_read(10'h105);
    n_vec++; if (bus.IO_R_Mem_value[8:0] !== 9'h1AB) begin n_err++; $display("FAIL mem_bank0_read: got %h want 1ab", bus.IO_R_Mem_value[8:0]); end
    send_frame(8'h05, 8'h11, 8'hCD, 8'h00);
    @(negedge clk);
    mem_read(10'h105);
    n_vec++; if (bus.IO_R_Mem_value !== {9'h0CD, 9'h1AB}) begin n_err++; $display("FAIL mem_bank1_read: got %h want %h", bus.IO_R_Mem_value, {9'h0CD, 9'h1AB}); end
  endtask

  task automatic test_read_during_write;
    bus.IO_R_Mem_addr = 10'h105;
    send_frame(8'h05, 8'h01, 8'h55, 8'h00);
    @(negedge clk);
    n_vec++; if (bus.IO_R_Mem_value[8:0] !== 9'h1AB) begin n_err++; $display("FAIL rdw_old_data: got %h want 1ab", bus.IO_R_Mem_value[8:0]); end
    @(negedge clk);
    n_vec++; if (bus.IO_R_Mem_value[8:0] !== 9'h055) begin n_err++; $display("FAIL rdw_new_data: got %h want 055", bus.IO_R_Mem_value[8:0]); end
  endtask

  task automatic test_flag_basic;
    send_frame(8'h03, 8'h80, 8'h02, 8'h00);
    @(negedge clk);
    flag_read(4'd3);
    n_vec++; if (bus.IO_Flag_value !== 2'd2) begin n_err++; $display("FAIL flag_read_first: got %0d want 2", bus.IO_Flag_value); end
    flag_read(4'd3);
    n_vec++; if (bus.IO_Flag_value !== 2'd0) begin n_err++; $display("FAIL flag_read_cleared: got %0d want 0", bus.IO_Flag_value); end
  endtask

  task automatic test_flag_collision;
    send_frame(8'h03, 8'h80, 8'h01, 8'h00);
    @(negedge clk);
    send_frame(8'h03, 8'h80, 8'h02, 8'h00);
    flag_read(4'd3);
    n_vec++; if (bus.IO_Flag_value !== 2'd1) begin n_err++; $display("FAIL coll_same_old: got %0d want 1", bus.IO_Flag_value); end
    flag_read(4'd3);
    n_vec++; if (bus.IO_Flag_value !== 2'd2) begin n_err++; $display("FAIL coll_same_new: got %0d want 2", bus.IO_Flag_value); end
    send_frame(8'h04, 8'h80, 8'h03, 8'h00);
    @(negedge clk);
    send_frame(8'h03, 8'h80, 8'h01, 8'h00);
    @(negedge clk);
    send_frame(8'h03, 8'h80, 8'h02, 8'h00);
    flag_read(4'd4);
    n_vec++; if (bus.IO_Flag_value !== 2'd3) begin n_err++; $display("FAIL coll_diff_read: got %0d want 3", bus.IO_Flag_value); end
    flag_read(4'd4);
    n_vec++; if (bus.IO_Flag_value !== 2'd0) begin n_err++; $display("FAIL coll_diff_cleared: got %0d want 0", bus.IO_Flag_value); end
    flag_read(4'd3);
    n_vec++; if (bus.IO_Flag_value !== EXP_ACC) begin n_err++; $display("FAIL coll_diff_written: got %0d want %0d", bus.IO_Flag_value, EXP_ACC); end
  endtask

  task automatic test_abort;
    logic [7:0] e0;
    int d0;
    e0 = bus.IO_Frame_err_cnt;
    d0 = done_cnt;
    send_byte(8'h11);
    send_byte(8'h01);
    bus.IO_SPI_cs = 1'b1;
    repeat (3) @(negedge clk);
    bus.IO_SPI_cs = 1'b0;
    repeat (3) @(negedge clk);
    n_vec++; if (bus.IO_Frame_err_cnt !== e0 + 8'd1) begin n_err++; $display("FAIL abort_err: got %0d want %0d", bus.IO_Frame_err_cnt, e0 + 8'd1); end
    send_frame(8'hC3, 8'h12, 8'hF0, 8'h00);
    n_vec++; if (bus.IO_Frame_done !== 1'b1) begin n_err++; $display("FAIL abort_next_done: got %b want 1", bus.IO_Frame_done); end
    @(negedge clk);
    mem_read(10'h2C3);
    n_vec++; if (bus.IO_R_Mem_value[17:9] !== 9'h0F0) begin n_err++; $display("FAIL abort_next_data: got %h want 0f0", bus.IO_R_Mem_value[17:9]); end
    n_vec++; if (done_cnt !== d0 + 1) begin n_err++; $display("FAIL abort_done_count: got %0d want %0d", done_cnt, d0 + 1); end
  endtask

  task automatic test_bad_bank;
    logic [7:0] e0;
    int d0;
    send_frame(8'h00, 8'h10, 8'h11, 8'h01);
    @(negedge clk);
    e0 = bus.IO_Frame_err_cnt;
    d0 = done_cnt;
    send_frame(8'h00, 8'h70, 8'h55, 8'h00);
    n_vec++; if (bus.IO_Frame_done !== 1'b0) begin n_err++; $display("FAIL bad_bank_done: got %b want 0", bus.IO_Frame_done); end
    @(negedge clk);
    n_vec++; if (bus.IO_Frame_err_cnt !== e0 + 8'd1) begin n_err++; $display("FAIL bad_bank_err: got %0d want %0d", bus.IO_Frame_err_cnt, e0 + 8'd1); end
    mem_read(10'h000);
    n_vec++; if (bus.IO_R_Mem_value[17:9] !== 9'h111) begin n_err++; $display("FAIL bad_bank_nowrite: got %h want 111", bus.IO_R_Mem_value[17:9]); end
    for (int i = 0; i < 300; i++) send_frame(8'h00, 8'h70, 8'h00, 8'h00);
    @(negedge clk);
    n_vec++; if (bus.IO_Frame_err_cnt !== 8'hFF) begin n_err++; $display("FAIL err_saturate: got %0d want 255", bus.IO_Frame_err_cnt); end
    n_vec++; if (done_cnt !== d0) begin n_err++; $display("FAIL bad_bank_done_count: got %0d want %0d", done_cnt, d0); end
  endtask

  task automatic test_reset_mid_frame;
    send_frame(8'h03, 8'h80, 8'h01, 8'h00);
    @(negedge clk);
    send_byte(8'h09);
    send_byte(8'h80);
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    n_vec++; if (bus.IO_Frame_err_cnt !== 8'd0) begin n_err++; $display("FAIL midrst_err: got %0d want 0", bus.IO_Frame_err_cnt); end
    n_vec++; if (bus.IO_Flag_value !== 2'd0) begin n_err++; $display("FAIL midrst_flag_value: got %0d want 0", bus.IO_Flag_value); end
    repeat (3) @(negedge clk);
    flag_read(4'd3);
    n_vec++; if (bus.IO_Flag_value !== 2'd0) begin n_err++; $display("FAIL midrst_flag_cleared: got %0d want 0", bus.IO_Flag_value); end
    send_frame(8'h05, 8'h80, 8'h01, 8'h00);
    n_vec++; if (bus.IO_Frame_done !== 1'b1) begin n_err++; $display("FAIL midrst_frame_aligned: got %b want 1", bus.IO_Frame_done); end
    @(negedge clk);
    send_frame(8'h05, 8'h80, 8'h02, 8'h00);
    @(negedge clk);
    flag_read(4'd5);
    n_vec++; if (bus.IO_Flag_value !== EXP_ACC) begin n_err++; $display("FAIL flag_accumulate: got %0d want %0d", bus.IO_Flag_value, EXP_ACC); end
    n_vec++; if (bus.IO_Frame_err_cnt !== 8'd0) begin n_err++; $display("FAIL midrst_err_final: got %0d want 0", bus.IO_Frame_err_cnt); end
  endtask

  initial begin
    test_reset();
    test_mem_write();
    test_read_during_write();
    test_flag_basic();
    test_flag_collision();
    test_abort();
    test_bad_bank();
    test_reset_mid_frame();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
